half_window_accumulator: RTL and testbench

- Downstream consumer of the uint8-to-half converter: sums a window of N_TERMS consecutive non-negative binary16 values and emits the binary16 sum.
- Feeds the kernel/averaging stage with one sum per window, for example 9 pixels of a 3x3 neighbourhood.
- Uses a multi-cycle FSM with a single shared aligner/adder, plus valid/ready handshakes on both sides.

---
 rtl/half_window_accumulator.sv | 219 +++++++++++++++++++++
 tb/tb_half_window_accumulator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_window_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : half_window_accumulator
//  Purpose  : Sums a window of N_TERMS non-negative binary16 operands with a
//             single shared align/add datapath and returns the binary16 sum
//             through valid/ready handshakes. Round-toward-zero, saturating
//             at 0x7BFF.
//  Revision : 1.0 - initial release
// ============================================================================
module half_window_accumulator #(
  parameter int N_TERMS = 9,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_ADD    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Largest finite binary16 magnitude (65504); used for Inf/NaN and overflow.
  localparam logic [14:0] MAX_MAG  = 15'h7BFF;
  localparam logic [4:0]  EXP_INF  = 5'h1F;
  localparam logic [4:0]  SIG_BITS = 5'd11;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  // Accumulator and operand are kept as magnitudes: the sign is always zero.
  logic [14:0]      acc_q,       acc_d;
  logic [14:0]      op_q,        op_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  // Aligned operands handed from ALIGN to ADD.
  logic [4:0]       res_exp_q,   res_exp_d;
  logic [10:0]      sig_big_q,   sig_big_d;
  logic [10:0]      sig_small_q, sig_small_d;
  logic [14:0]      out_data_q,  out_data_d;

  // --------------------------------------------------------------------------
  // Combinational intermediates
  // --------------------------------------------------------------------------
  logic        sign_unused;
  logic [14:0] in_mag;

  logic [4:0]  acc_exp;
  logic [4:0]  op_exp;
  logic [10:0] acc_sig;
  logic [10:0] op_sig;
  logic [4:0]  align_exp;
  logic [10:0] align_big;
  logic [10:0] align_small_raw;
  logic [4:0]  align_diff;
  logic [10:0] align_small;

  logic [11:0] sum;
  logic [5:0]  norm_exp;
  logic [9:0]  norm_frac;
  logic [14:0] add_res;

  // The operand sign is discarded: every value is treated as positive.
  assign sign_unused = in_data[15];

  // Sanitise the incoming operand: flush zero/subnormal, clamp Inf/NaN.
  always_comb begin
    in_mag = in_data[14:0];
    if (in_data[14:10] == 5'd0) begin
      in_mag = 15'h0000;
    end else if (in_data[14:10] == EXP_INF) begin
      in_mag = MAX_MAG;
    end
  end

  // Alignment: pick the larger exponent and shift the smaller significand.
  // A zero value (exp==0) carries a zero significand, so adding to or from a
  // zero accumulator naturally reproduces the other operand exactly.
  always_comb begin
    acc_exp = acc_q[14:10];
    op_exp  = op_q[14:10];
    acc_sig = (acc_exp == 5'd0) ? 11'd0 : {1'b1, acc_q[9:0]};
    op_sig  = (op_exp  == 5'd0) ? 11'd0 : {1'b1, op_q[9:0]};

    if (acc_exp >= op_exp) begin
      align_exp       = acc_exp;
      align_big       = acc_sig;
      align_small_raw = op_sig;
      align_diff      = acc_exp - op_exp;
    end else begin
      align_exp       = op_exp;
      align_big       = op_sig;
      align_small_raw = acc_sig;
      align_diff      = op_exp - acc_exp;
    end

    // Shifting by 11 or more leaves nothing of an 11-bit significand.
    if (align_diff >= SIG_BITS) begin
      align_small = 11'd0;
    end else begin
      align_small = align_small_raw >> align_diff;
    end
  end

  // Addition and single-step renormalisation with truncation and saturation.
  always_comb begin
    sum = {1'b0, sig_big_q} + {1'b0, sig_small_q};
    if (sum[11]) begin
      norm_exp  = {1'b0, res_exp_q} + 6'd1;
      norm_frac = sum[10:1];
    end else begin
      norm_exp  = {1'b0, res_exp_q};
      norm_frac = sum[9:0];
    end

    // Both inputs zero gives exp 0 and frac 0, i.e. an exact zero.
    if (norm_exp >= {1'b0, EXP_INF}) begin
      add_res = MAX_MAG;
    end else begin
      add_res = {norm_exp[4:0], norm_frac};
    end
  end

  // Next-state logic for the ACCEPT -> ALIGN -> ADD -> (ACCEPT | DONE) loop.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    res_exp_d   = res_exp_q;
    sig_big_d   = sig_big_q;
    sig_small_d = sig_small_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_ACCEPT: begin
        if (in_valid) begin
          op_d    = in_mag;
          state_d = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        res_exp_d   = align_exp;
        sig_big_d   = align_big;
        sig_small_d = align_small;
        state_d     = ST_ADD;
      end

      ST_ADD: begin
        acc_d = add_res;
        if (cnt_q == LAST_CNT) begin
          out_data_d = add_res;
          state_d    = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_ACCEPT;
        end
      end

      ST_DONE: begin
        // The result register is left alone so out_data only moves on the
        // next ADD->DONE transition.
        if (out_ready) begin
          acc_d   = 15'h0000;
          cnt_d   = '0;
          state_d = ST_ACCEPT;
        end
      end

      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // Register update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_ACCEPT;
      acc_q       <= 15'h0000;
      op_q        <= 15'h0000;
      cnt_q       <= '0;
      res_exp_q   <= 5'd0;
      sig_big_q   <= 11'd0;
      sig_small_q <= 11'd0;
      out_data_q  <= 15'h0000;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      res_exp_q   <= res_exp_d;
      sig_big_q   <= sig_big_d;
      sig_small_q <= sig_small_d;
      out_data_q  <= out_data_d;
    end
  end

  // in_ready is gated by reset so it reads 0 while n_rst is held low, then
  // rises in the very first ACCEPT cycle after release.
  assign in_ready  = n_rst & (state_q == ST_ACCEPT);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = {1'b0, out_data_q};

endmodule
`default_nettype wire

// File: tb/tb_half_window_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_half_window_accumulator
//  Purpose  : Self-checking bench for half_window_accumulator: directed table
//             of windows, hand-written timing/back-pressure/reset sequences
//             and randomized windows against an exact fixed-point model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_half_window_accumulator;

  localparam int N_TERMS = 9;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  int vec_count;
  int miscompares;

  half_window_accumulator #(.N_TERMS(N_TERMS), .CNT_W(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [N_TERMS-1:0][15:0] ops_t;

  typedef struct {
    string       name;
    ops_t        ops;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs [10];

  // ---------------------------------------------------------------- helpers
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    vec_count++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    vec_count++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ops_t mk(input logic [15:0] a, input int n, input logic [15:0] b);
    ops_t r;
    for (int i = 0; i < N_TERMS; i++) r[i] = (i < n) ? a : b;
    return r;
  endfunction

  // ------------------------------------------------------ reference model
  // Values are exact integers in units of 2^-24 (one ulp of the smallest
  // normal); each step is the exact sum truncated back to binary16.
  function automatic longint half_to_fix(input logic [15:0] h_in);
    logic [15:0] h;
    int e;
    h = h_in;
    e = int'(h[14:10]);
    if (e == 0) return 64'sd0;
    if (e == 31) begin
      h = 16'h7BFF;
      e = 30;
    end
    return longint'({1'b1, h[9:0]}) << (e - 1);
  endfunction

  function automatic logic [15:0] fix_to_half_rtz(input longint x);
    int p;
    int e;
    longint m;
    if (x == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 63; i++) if (x[i]) p = i;
    e = p - 9;
    if (e >= 31) return 16'h7BFF;
    m = x >>> (p - 10);
    return {1'b0, e[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] model_window(input ops_t ops);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < N_TERMS; i++)
      acc = fix_to_half_rtz(half_to_fix(acc) + half_to_fix(ops[i]));
    return acc;
  endfunction

  // ---------------------------------------------------------- transactions
  // Offer one operand and return just after its acceptance edge. With hold
  // set, in_valid stays high carrying junk that must be ignored.
  task automatic feed_op(input logic [15:0] d, input bit hold);
    int waits;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waits < 40) begin
      tick();
      waits++;
    end
    if (!in_ready) begin
      vec_count++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1 within 40 cycles");
    end
    tick();
    if (hold) begin
      in_data = 16'($urandom);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input string name);
    int waits;
    waits = 0;
    while (!out_valid && waits < 20) begin
      tick();
      waits++;
    end
    check1({name, "_out_valid"}, out_valid, 1'b1);
  endtask

  task automatic finish_window(input string name, input logic [15:0] req);
    wait_out(name);
    check16({name, "_out_data"}, out_data, req);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1({name, "_out_valid_drop"}, out_valid, 1'b0);
  endtask

  task automatic run_window(input string name, input ops_t ops, input logic [15:0] req, input bit hold);
    for (int i = 0; i < N_TERMS; i++) begin
      feed_op(ops[i], hold);
      if (!hold) repeat ($urandom_range(0, 2)) tick();
    end
    finish_window(name, req);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] h;
    int sel;
    h   = 16'($urandom);
    sel = $urandom_range(0, 11);
    if (sel == 0)      h[14:10] = 5'd0;
    else if (sel == 1) h[14:10] = 5'd31;
    else if (sel == 2) h[14:10] = 5'($urandom_range(21, 30));
    else               h[14:10] = 5'($urandom_range(8, 20));
    return h;
  endfunction

  // ------------------------------------------------------------------ test
  initial begin
    ops_t rops;

    vec_count   = 0;
    miscompares = 0;
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;

    vecs[0] = '{name: "ones",        ops: mk(16'h3C00, 9, 16'h0000), expected: 16'h4880};
    vecs[1] = '{name: "v255",        ops: mk(16'h5BF8, 9, 16'h0000), expected: 16'h687B};
    vecs[2] = '{name: "zeros",       ops: mk(16'h0000, 9, 16'h0000), expected: 16'h0000};
    vecs[3] = '{name: "one_zeros",   ops: mk(16'h3C00, 1, 16'h0000), expected: 16'h3C00};
    vecs[4] = '{name: "saturate",    ops: mk(16'h7800, 2, 16'h3C00), expected: 16'h7BFF};
    vecs[5] = '{name: "neg_ones",    ops: mk(16'hBC00, 9, 16'h0000), expected: 16'h4880};
    vecs[6] = '{name: "inf_clamp",   ops: mk(16'hFC00, 1, 16'h0000), expected: 16'h7BFF};
    vecs[7] = '{name: "subnormals",  ops: mk(16'h0001, 9, 16'h0000), expected: 16'h0000};
    vecs[8] = '{name: "big_diff",    ops: mk(16'h7000, 1, 16'h3C00), expected: 16'h7000};
    vecs[9] = '{name: "small_first", ops: mk(16'h3C00, 8, 16'h7000), expected: 16'h7001};

    // Reset state
    repeat (3) tick();
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check16("rst_out_data", out_data, 16'h0000);
    n_rst = 1'b1;
    #1;
    check1("post_rst_in_ready", in_ready, 1'b1);

    // Nine 1.0 with in_valid held: ready pattern 1,0,0 and 3-cycle latency
    for (int i = 0; i < N_TERMS; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h3C00;
      check1("ready_phase0", in_ready, 1'b1);
      tick();
      in_data = 16'($urandom);
      check1("ready_phase1", in_ready, 1'b0);
      check1("valid_phase1", out_valid, 1'b0);
      tick();
      check1("ready_phase2", in_ready, 1'b0);
      check1("valid_phase2", out_valid, 1'b0);
      tick();
      check1("valid_phase3", out_valid, (i == N_TERMS - 1) ? 1'b1 : 1'b0);
    end
    finish_window("ones_timing", 16'h4880);

    // Directed table, alternating held and gapped in_valid
    for (int k = 0; k < 10; k++)
      run_window(vecs[k].name, vecs[k].ops, vecs[k].expected, k[0]);

    // Back-pressure in DONE with in_valid asserted
    for (int i = 0; i < N_TERMS; i++) feed_op(16'h3C00, 1'b1);
    wait_out("bp");
    in_valid = 1'b1;
    in_data  = 16'h3C00;
    for (int c = 0; c < 10; c++) begin
      check1("bp_out_valid", out_valid, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
      check16("bp_out_data", out_data, 16'h4880);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1("bp_release_valid", out_valid, 1'b0);
    check1("bp_release_ready", in_ready, 1'b1);
    for (int i = 0; i < N_TERMS; i++) feed_op(16'h3C00, 1'b1);
    finish_window("bp_next", 16'h4880);

    // Reset pulled in the middle of a window (ALIGN after 4th operand)
    for (int i = 0; i < 4; i++) feed_op(16'h3C00, 1'b0);
    n_rst = 1'b0;
    #1;
    check1("midrst_in_ready", in_ready, 1'b0);
    check1("midrst_out_valid", out_valid, 1'b0);
    check16("midrst_out_data", out_data, 16'h0000);
    repeat (2) tick();
    n_rst = 1'b1;
    #1;
    check1("midrst_release_ready", in_ready, 1'b1);
    run_window("after_rst", mk(16'h3C00, 9, 16'h0000), 16'h4880, 1'b0);

    // Randomized windows against the model
    for (int w = 0; w < 25; w++) begin
      for (int i = 0; i < N_TERMS; i++) rops[i] = rand_op();
      run_window("random", rops, model_window(rops), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
